// File: rtl/sr_cmd_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// sr_cmd_conditioner_pkg
// Shared definitions for the command conditioner: default synchroniser depth
// and debounce length, the packed output-pulse bundle, and the set/clear
// arbitration helper used by the top level.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package sr_cmd_conditioner_pkg;

  // Default flops per synchroniser chain (usable range 2..4)
  localparam int SYNC_STAGES_DEF = 2;
  // Default number of consecutive equal samples needed to accept a new level
  localparam int DB_CYCLES_DEF   = 4;

  // One-cycle pulses presented to the downstream SR flip-flop
  typedef struct packed {
    logic set;
    logic clr;
    logic conflict;
  } cmd_pulse_t;

  // Clear always wins a same-cycle collision; the losing set edge is dropped
  // for good rather than queued, so the flip-flop never sees set and reset
  // together.
  function automatic cmd_pulse_t arbitrate(input logic setRise, input logic clrRise);
    cmd_pulse_t p;
    p.set      = setRise & ~clrRise;
    p.clr      = clrRise;
    p.conflict = setRise & clrRise;
    return p;
  endfunction

endpackage

// File: rtl/sr_cmd_conditioner_debounce_ch.sv
// ----------------------------------------------------------------------------
// debounce_ch
// One conditioning channel: synchronises a raw asynchronous input, debounces
// it with a saturating qualification counter, and flags the rising edge of
// the debounced level.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous reset, active-low
//   i_raw   in  raw, possibly bouncing input
//   o_lvl   out debounced level (registered)
//   o_rise  out high for the one cycle after o_lvl goes 0 -> 1
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module debounce_ch
  import sr_cmd_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise
);

  localparam int                CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_lvl;
  logic                   r_lvlDly;
  logic                   w_sample;

  // Only the last synchroniser stage is safe to look at
  assign w_sample = r_sync[SYNC_STAGES-1];

  // Synchroniser shift, debounce counter and debounced level.
  // The counter only advances while the sample disagrees with the accepted
  // level; any agreeing sample restarts qualification, which is what rejects
  // short glitches. On the DB_CYCLES-th disagreeing sample the new level is
  // taken and the counter cleared, so it never passes CNT_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_lvl    <= 1'b0;
      r_lvlDly <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_lvlDly <= r_lvl;
      if (w_sample == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_lvl <= w_sample;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_lvl & ~r_lvlDly;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// ----------------------------------------------------------------------------
// sr_cmd_conditioner
// Turns raw bouncy set/clear request lines into clean, mutually exclusive
// single-cycle pulses that drive an SR flip-flop's set and reset inputs.
// Ports:
//   clk         in  system clock, rising edge
//   rst         in  asynchronous reset, active-low
//   set_raw     in  raw set request (asynchronous, may bounce)
//   clr_raw     in  raw clear request (asynchronous, may bounce)
//   set_o       out one-cycle set pulse
//   clr_o       out one-cycle clear pulse
//   conflict_o  out one-cycle flag: set and clear edges accepted together
//   set_lvl_o   out debounced set level
//   clr_lvl_o   out debounced clear level
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module sr_cmd_conditioner
  import sr_cmd_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic set_o,
  output logic clr_o,
  output logic conflict_o,
  output logic set_lvl_o,
  output logic clr_lvl_o
);

  logic       w_setRise;
  logic       w_clrRise;
  cmd_pulse_t r_pulse;

  debounce_ch #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_setCh (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (set_raw),
    .o_lvl  (set_lvl_o),
    .o_rise (w_setRise)
  );

  debounce_ch #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_clrCh (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (clr_raw),
    .o_lvl  (clr_lvl_o),
    .o_rise (w_clrRise)
  );

  // Registered arbitration so the outputs are glitch-free flop outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= arbitrate(w_setRise, w_clrRise);
    end
  end

  assign set_o      = r_pulse.set;
  assign clr_o      = r_pulse.clr;
  assign conflict_o = r_pulse.conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_conditioner
// Directed bench for sr_cmd_conditioner with a pulse scoreboard. Stimulus
// pushes each expected output pulse (cycle number and value) into a queue; a
// monitor pops and compares whenever any pulse output is high, flags pulses
// that never appear, and checks set/clear exclusivity every cycle. A small
// behavioural SR flip-flop is driven by the pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_cmd_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic set_raw;
  logic clr_raw;
  logic set_o;
  logic clr_o;
  logic conflict_o;
  logic set_lvl_o;
  logic clr_lvl_o;
  logic q;

  int cyc       = 0;
  int checkCnt  = 0;
  int passCnt   = 0;

  typedef struct {
    int   cyc;
    logic set;
    logic clr;
    logic conf;
  } exp_t;

  exp_t expQ[$];

  sr_cmd_conditioner #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_raw    (set_raw),
    .clr_raw    (clr_raw),
    .set_o      (set_o),
    .clr_o      (clr_o),
    .conflict_o (conflict_o),
    .set_lvl_o  (set_lvl_o),
    .clr_lvl_o  (clr_lvl_o)
  );

  // 2 ns clock
  always #1 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SR flip-flop fed by the conditioned pulses
  always @(posedge clk or negedge rst) begin
    if (!rst)       q <= 1'b0;
    else if (set_o) q <= 1'b1;
    else if (clr_o) q <= 1'b0;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic s, input logic c);
    set_raw = s;
    clr_raw = c;
  endtask

  task automatic pushExp(input int at, input logic s, input logic c, input logic cf);
    exp_t e;
    e.cyc  = at;
    e.set  = s;
    e.clr  = c;
    e.conf = cf;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      checkOutput("set_clr_exclusive", int'(set_o & clr_o), 0);
      if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        checkCnt++;
        $display("[TB] FAIL pulse_missing: no pulse observed, expected {set,clr,conf}=%b%b%b at cycle %0d (now %0d)",
                 e.set, e.clr, e.conf, e.cyc, cyc);
      end
      if (set_o | clr_o | conflict_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", int'({set_o, clr_o, conflict_o}), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulse_cycle", cyc, e.cyc);
          checkOutput("pulse_value", int'({set_o, clr_o, conflict_o}), int'({e.set, e.clr, e.conf}));
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int c0;
    int d;
    logic sawLvl;
    logic bounce [5];
    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Test 1: reset with both requests high, then release -> clear wins
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'({set_o, clr_o, conflict_o, set_lvl_o, clr_lvl_o}), 0);
    c0 = cyc;
    rst = 1'b1;
    pushExp(c0 + 7, 1'b0, 1'b1, 1'b1);
    waitUntil(c0 + 10);
    checkOutput("t1_q_after_clear", int'(q), 0);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c0 + 22);
    checkOutput("t1_queue_drained", expQ.size(), 0);

    // Test 2: clean set held for 40 ns
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    pushExp(c0 + 7, 1'b1, 1'b0, 1'b0);
    waitUntil(c0 + 5);
    checkOutput("t2_lvl_before", int'(set_lvl_o), 0);
    waitUntil(c0 + 6);
    checkOutput("t2_lvl_after", int'(set_lvl_o), 1);
    waitUntil(c0 + 12);
    checkOutput("t2_q_set", int'(q), 1);
    waitUntil(c0 + 20);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c0 + 32);
    checkOutput("t2_lvl_fallen", int'(set_lvl_o), 0);
    checkOutput("t2_queue_drained", expQ.size(), 0);

    // Test 3: bouncing set request, one pulse after 4 steady samples
    c0 = cyc;
    pushExp(c0 + 11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bounce[i], 1'b0);
      @(negedge clk);
    end
    waitUntil(c0 + 9);
    checkOutput("t3_lvl_before", int'(set_lvl_o), 0);
    waitUntil(c0 + 10);
    checkOutput("t3_lvl_after", int'(set_lvl_o), 1);
    waitUntil(c0 + 20);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c0 + 32);
    checkOutput("t3_queue_drained", expQ.size(), 0);

    // Test 4: two-cycle clear glitch is rejected
    c0 = cyc;
    applyStimulus(1'b0, 1'b1);
    waitUntil(c0 + 2);
    applyStimulus(1'b0, 1'b0);
    sawLvl = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sawLvl |= clr_lvl_o;
      @(negedge clk);
    end
    checkOutput("t4_clr_lvl_never", int'(sawLvl), 0);
    checkOutput("t4_q_unchanged", int'(q), 1);

    // Test 5: simultaneous set and clear -> clear wins, conflict flagged
    c0 = cyc;
    applyStimulus(1'b1, 1'b1);
    pushExp(c0 + 7, 1'b0, 1'b1, 1'b1);
    waitUntil(c0 + 10);
    checkOutput("t5_q_cleared", int'(q), 0);
    waitUntil(c0 + 15);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c0 + 27);
    checkOutput("t5_queue_drained", expQ.size(), 0);

    // Test 6: reset mid-debounce, then full requalification
    c0 = cyc;
    applyStimulus(1'b1, 1'b0);
    waitUntil(c0 + 4);
    rst = 1'b0;
    #0.2;
    checkOutput("t6_reset_outputs", int'({set_o, clr_o, conflict_o, set_lvl_o}), 0);
    waitUntil(c0 + 6);
    d = cyc;
    rst = 1'b1;
    pushExp(d + 7, 1'b1, 1'b0, 1'b0);
    waitUntil(d + 5);
    checkOutput("t6_lvl_before", int'(set_lvl_o), 0);
    waitUntil(d + 6);
    checkOutput("t6_lvl_after", int'(set_lvl_o), 1);
    waitUntil(d + 12);
    checkOutput("t6_q_set", int'(q), 1);
    waitUntil(d + 20);
    applyStimulus(1'b0, 1'b0);
    waitUntil(d + 32);
    checkOutput("t6_queue_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
